// File: rtl/movegen_pkg.sv
// Shared types for the move-generation sequencer: board control encodings,
// the sequencer FSM states and the layout of the board's data_out word.
// Optional build macro: MOVEGEN_LEGAL_CHECK_EN adds the make/unmake legality states.
package movegen_pkg;

  // Board operation requested through state_mode.
  typedef enum logic [2:0] {
    SM_IDLE        = 3'd0,
    SM_FIND_VICTIM = 3'd1,
    SM_FIND_AGGR   = 3'd2,
    SM_MAKE        = 3'd3,
    SM_UNMAKE      = 3'd4
  } state_mode_e;

  // Board mask operation requested through mask_mode.
  typedef enum logic [1:0] {
    MK_NONE      = 2'd0,
    MK_AGGR      = 2'd1,
    MK_VICTIM    = 2'd2,
    MK_CLEAR_ALL = 2'd3
  } mask_mode_e;

  // Sequencer states.
  typedef enum logic [3:0] {
    StIdle,
    StClr,
    StFv,
    StFa,
`ifdef MOVEGEN_LEGAL_CHECK_EN
    StMk,
    StUm,
`endif
    StEmit,
    StMa,
    StMv,
    StFin
  } gen_state_e;

  // board_data field positions.
  localparam int unsigned BdFoundBit = 6;
  localparam int unsigned BdSqMsb    = 5;

  // States that must let the board settle before sampling its outputs.
  function automatic logic is_wait(gen_state_e s);
`ifdef MOVEGEN_LEGAL_CHECK_EN
    return (s == StFv) || (s == StFa) || (s == StMk) || (s == StUm);
`else
    return (s == StFv) || (s == StFa);
`endif
  endfunction

endpackage

// File: rtl/movegen_seq_settle_timer.sv
// Loadable down-counter with a zero flag; counts out the board pipeline
// latency after each change of board control.
module settle_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] cnt_q;

  // Load on request, otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/movegen_seq.sv
// MVV-LVA move-generation sequencer: drives the board array to find the most
// valuable victim, walks its aggressors cheapest-first and streams each
// (from,to) pair over a valid/ready handshake.
// Optional build macro: MOVEGEN_LEGAL_CHECK_EN inserts a make/unmake pass that
// drops moves leaving the own king in check.
module movegen_seq
  import movegen_pkg::*;
#(
  parameter int unsigned BOARD_LAT = 2,
  parameter int unsigned MAX_MOVES = 218
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       side,
  output logic [2:0] state_mode,
  output logic [1:0] mask_mode,
  output logic       wtm,
  output logic [5:0] ss1,
  output logic       ss1_valid,
  output logic [5:0] ss2,
  output logic       ss2_valid,
  input  logic [6:0] board_data,
  input  logic       board_illegal,
  output logic       mv_valid,
  input  logic       mv_ready,
  output logic [5:0] mv_from,
  output logic [5:0] mv_to,
  output logic       busy,
  output logic       done,
  output logic [7:0] move_count
);

  gen_state_e state_q, state_d;
  logic [5:0] victim_q, victim_d;
  logic [5:0] aggr_q, aggr_d;
  logic       wtm_q, wtm_d;
  logic [7:0] count_q, count_d;
  logic [8:0] count_inc;
  logic       timer_load, timer_zero;
  logic       found;
  logic [5:0] bsq;

  assign found     = board_data[BdFoundBit];
  assign bsq       = board_data[BdSqMsb:0];
  assign count_inc = {1'b0, count_q} + 9'd1;

`ifdef MOVEGEN_LEGAL_CHECK_EN
  logic illegal_q, illegal_d;
`else
  logic unused_illegal;
  assign unused_illegal = board_illegal;
`endif

  // Reload the settle timer whenever a WAIT state is freshly entered.
  assign timer_load = (state_d != state_q) && is_wait(state_d);

  settle_timer #(
    .Width(3)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(3'(BOARD_LAT)),
    .zero    (timer_zero)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      victim_q <= '0;
      aggr_q   <= '0;
      wtm_q    <= 1'b0;
      count_q  <= '0;
`ifdef MOVEGEN_LEGAL_CHECK_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      aggr_q   <= aggr_d;
      wtm_q    <= wtm_d;
      count_q  <= count_d;
`ifdef MOVEGEN_LEGAL_CHECK_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    aggr_d     = aggr_q;
    wtm_d      = wtm_q;
    count_d    = count_q;
`ifdef MOVEGEN_LEGAL_CHECK_EN
    illegal_d  = illegal_q;
`endif
    state_mode = SM_IDLE;
    mask_mode  = MK_NONE;
    ss1        = '0;
    ss1_valid  = 1'b0;
    ss2        = '0;
    ss2_valid  = 1'b0;
    mv_valid   = 1'b0;
    mv_from    = '0;
    mv_to      = '0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClr;
          wtm_d   = side;
          count_d = '0;
        end
      end
      StClr: begin
        mask_mode = MK_CLEAR_ALL;
        state_d   = StFv;
      end
      StFv: begin
        state_mode = SM_FIND_VICTIM;
        if (timer_zero) begin
          if (found) begin
            victim_d = bsq;
            state_d  = StFa;
          end else begin
            state_d = StFin;
          end
        end
      end
      StFa: begin
        state_mode = SM_FIND_AGGR;
        ss1        = victim_q;
        ss1_valid  = 1'b1;
        if (timer_zero) begin
          if (found) begin
            aggr_d = bsq;
`ifdef MOVEGEN_LEGAL_CHECK_EN
            state_d = StMk;
`else
            state_d = StEmit;
`endif
          end else begin
            state_d = StMv;
          end
        end
      end
`ifdef MOVEGEN_LEGAL_CHECK_EN
      StMk: begin
        state_mode = SM_MAKE;
        ss1        = victim_q;
        ss1_valid  = 1'b1;
        ss2        = aggr_q;
        ss2_valid  = 1'b1;
        if (timer_zero) begin
          illegal_d = board_illegal;
          state_d   = StUm;
        end
      end
      StUm: begin
        state_mode = SM_UNMAKE;
        ss1        = victim_q;
        ss1_valid  = 1'b1;
        ss2        = aggr_q;
        ss2_valid  = 1'b1;
        if (timer_zero) begin
          state_d = illegal_q ? StMa : StEmit;
        end
      end
`endif
      StEmit: begin
        mv_valid = 1'b1;
        mv_from  = aggr_q;
        mv_to    = victim_q;
        if (mv_ready) begin
          if ({1'b0, count_q} < 9'(MAX_MOVES)) begin
            count_d = count_inc[7:0];
          end
          state_d = (count_inc >= 9'(MAX_MOVES)) ? StFin : StMa;
        end
      end
      StMa: begin
        mask_mode = MK_AGGR;
        ss2       = aggr_q;
        ss2_valid = 1'b1;
        state_d   = StFa;
      end
      StMv: begin
        // The board also drops all aggressor masks on a victim mask.
        mask_mode = MK_VICTIM;
        ss1       = victim_q;
        ss1_valid = 1'b1;
        state_d   = StFv;
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort beats everything, including a handshake in this cycle.
    if (abort) begin
      state_d  = StIdle;
      victim_d = '0;
      aggr_d   = '0;
      wtm_d    = 1'b0;
      count_d  = count_q;
`ifdef MOVEGEN_LEGAL_CHECK_EN
      illegal_d = 1'b0;
`endif
    end
  end

  assign wtm        = wtm_q;
  assign busy       = (state_q != StIdle);
  assign move_count = count_q;

endmodule

// File: tb/tb_movegen_seq.sv
// Bench for movegen_seq: a behavioural board with a BOARD_LAT-deep output
// pipeline answers find/make requests from a small per-scenario piece table.
module tb_movegen_seq;
  import movegen_pkg::*;

  localparam int unsigned Lat = 2;

  logic clk = 1'b0;
  logic rst, start, abort, side, mv_ready, sel;
  logic [6:0] board_data;
  logic       board_illegal;

  always #5 clk = ~clk;

  // DUT with default cap
  logic [2:0] sm0;  logic [1:0] mk0;  logic wtm0;
  logic [5:0] ss1_0, ss2_0;  logic ss1v0, ss2v0;
  logic mvv0, busy0, done0;  logic [5:0] from0, to0;  logic [7:0] cnt0;
  // DUT with MAX_MOVES=3
  logic [2:0] sm3;  logic [1:0] mk3;  logic wtm3;
  logic [5:0] ss1_3, ss2_3;  logic ss1v3, ss2v3;
  logic mvv3, busy3, done3;  logic [5:0] from3, to3;  logic [7:0] cnt3;
  logic start0, start3;

  assign start0 = start & ~sel;
  assign start3 = start & sel;

  movegen_seq #(.BOARD_LAT(Lat), .MAX_MOVES(218)) u_dut (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .side(side),
    .state_mode(sm0), .mask_mode(mk0), .wtm(wtm0),
    .ss1(ss1_0), .ss1_valid(ss1v0), .ss2(ss2_0), .ss2_valid(ss2v0),
    .board_data(board_data), .board_illegal(board_illegal),
    .mv_valid(mvv0), .mv_ready(mv_ready), .mv_from(from0), .mv_to(to0),
    .busy(busy0), .done(done0), .move_count(cnt0)
  );

  movegen_seq #(.BOARD_LAT(Lat), .MAX_MOVES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort), .side(side),
    .state_mode(sm3), .mask_mode(mk3), .wtm(wtm3),
    .ss1(ss1_3), .ss1_valid(ss1v3), .ss2(ss2_3), .ss2_valid(ss2v3),
    .board_data(board_data), .board_illegal(board_illegal),
    .mv_valid(mvv3), .mv_ready(mv_ready), .mv_from(from3), .mv_to(to3),
    .busy(busy3), .done(done3), .move_count(cnt3)
  );

  // Selected DUT view
  logic [2:0] b_sm;  logic [1:0] b_mk;  logic [5:0] b_ss1, b_ss2;
  logic o_valid, o_done, o_busy, o_wtm;  logic [5:0] o_from, o_to;  logic [7:0] o_count;
  always_comb begin
    b_sm    = sel ? sm3 : sm0;
    b_mk    = sel ? mk3 : mk0;
    b_ss1   = sel ? ss1_3 : ss1_0;
    b_ss2   = sel ? ss2_3 : ss2_0;
    o_valid = sel ? mvv3 : mvv0;
    o_done  = sel ? done3 : done0;
    o_busy  = sel ? busy3 : busy0;
    o_wtm   = sel ? wtm3 : wtm0;
    o_from  = sel ? from3 : from0;
    o_to    = sel ? to3 : to0;
    o_count = sel ? cnt3 : cnt0;
  end

  // Board model: victims in value order, aggressors cheapest-first
  int         nv;
  int         na[2];
  logic [5:0] vsq[2];
  logic [5:0] asq[2][3];
  bit         ill[2][3];
  bit         vmask[2];
  bit         amask[2][3];
  logic [6:0] resp;
  logic       resp_ill;
  logic [6:0] pipe_d[Lat];
  logic       pipe_i[Lat];

  always_comb begin
    resp     = '0;
    resp_ill = 1'b0;
    if (b_sm == 3'(SM_FIND_VICTIM)) begin
      for (int i = 1; i >= 0; i--)
        if (i < nv && !vmask[i]) resp = {1'b1, vsq[i]};
    end else if (b_sm == 3'(SM_FIND_AGGR)) begin
      for (int i = 1; i >= 0; i--)
        if (i < nv && vsq[i] == b_ss1)
          for (int j = 2; j >= 0; j--)
            if (j < na[i] && !amask[i][j]) resp = {1'b1, asq[i][j]};
    end else if (b_sm == 3'(SM_MAKE)) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 3; j++)
          if (i < nv && j < na[i] && vsq[i] == b_ss1 && asq[i][j] == b_ss2)
            resp_ill = ill[i][j];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (b_mk == 2'(MK_CLEAR_ALL)) vmask[i] <= 1'b0;
      if (b_mk == 2'(MK_VICTIM) && vsq[i] == b_ss1) vmask[i] <= 1'b1;
      for (int j = 0; j < 3; j++) begin
        if (b_mk == 2'(MK_CLEAR_ALL) || b_mk == 2'(MK_VICTIM)) amask[i][j] <= 1'b0;
        if (b_mk == 2'(MK_AGGR) && asq[i][j] == b_ss2) amask[i][j] <= 1'b1;
      end
    end
    pipe_d[0] <= resp;
    pipe_i[0] <= resp_ill;
    for (int k = 1; k < Lat; k++) begin
      pipe_d[k] <= pipe_d[k-1];
      pipe_i[k] <= pipe_i[k-1];
    end
  end

  assign board_data    = pipe_d[Lat-1];
  assign board_illegal = pipe_i[Lat-1];

  // Checking helpers
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic s);
    side  = s;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_scen(input int s);
    nv = 0;
    for (int i = 0; i < 2; i++) begin
      na[i] = 0;  vsq[i] = '0;
      for (int j = 0; j < 3; j++) begin asq[i][j] = '0; ill[i][j] = 1'b0; end
    end
    case (s)
      0: begin nv = 1; vsq[0] = 6'd59; na[0] = 1; asq[0][0] = 6'd3; end
      1: begin
        nv = 2; vsq[0] = 6'd36; vsq[1] = 6'd32;
        na[0] = 2; asq[0][0] = 6'd27; asq[0][1] = 6'd4;
        na[1] = 2; asq[1][0] = 6'd25; asq[1][1] = 6'd0;
      end
      2: begin
        nv = 2; vsq[0] = 6'd36; vsq[1] = 6'd32;
        na[0] = 3; asq[0][0] = 6'd27; asq[0][1] = 6'd4; asq[0][2] = 6'd19;
        na[1] = 2; asq[1][0] = 6'd25; asq[1][1] = 6'd0;
      end
      default: begin
        nv = 1; vsq[0] = 6'd36;
        na[0] = 2; asq[0][0] = 6'd27; asq[0][1] = 6'd4; ill[0][0] = 1'b1;
      end
    endcase
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (o_valid) ok = 1'b1;
      else step();
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      if (o_done) ok = 1'b1;
      else step();
    end
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] exp_cnt);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_sm"}, sm0, 0);
    chk({tag, "_mk"}, mk0, 0);
    chk({tag, "_ss1v"}, ss1v0, 0);
    chk({tag, "_ss2v"}, ss2v0, 0);
    chk({tag, "_mvv"}, mvv0, 0);
    chk({tag, "_from"}, from0, 0);
    chk({tag, "_wtm"}, wtm0, 0);
    chk({tag, "_cnt"}, cnt0, exp_cnt);
  endtask

  typedef struct packed {
    logic [1:0]      scen;
    logic            side;
    logic            use3;
    logic [3:0]      n;
    logic [4:0][5:0] fr;
    logic [4:0][5:0] to;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    load_scen(int'(v.scen));
    sel = v.use3;
    mv_ready = 1'b1;
    step();
    go(v.side);
    for (int c = 0; c < 2000 && !seen; c++) begin
      if (o_valid) begin
        if (k == 0) chk($sformatf("v%0d_wtm", idx), o_wtm, v.side);
        if (k < int'(v.n)) begin
          chk($sformatf("v%0d_from%0d", idx, k), o_from, v.fr[k]);
          chk($sformatf("v%0d_to%0d", idx, k), o_to, v.to[k]);
        end
        k++;
      end
      if (o_done) seen = 1'b1;
      else step();
    end
    chk($sformatf("v%0d_done", idx), seen, 1);
    chk($sformatf("v%0d_nmoves", idx), k, v.n);
    step();
    chk($sformatf("v%0d_count", idx), o_count, v.n);
    chk($sformatf("v%0d_idle", idx), o_busy, 0);
  endtask

  initial begin
    bit ok;
    int n;
    logic [5:0] f0, t0;

    vecs[0] = '0;  vecs[1] = '0;  vecs[2] = '0;  vecs[3] = '0;
    vecs[0].scen = 2'd0; vecs[0].side = 1'b0; vecs[0].n = 4'd1;
    vecs[0].fr[0] = 6'd3;  vecs[0].to[0] = 6'd59;
    vecs[1].scen = 2'd1; vecs[1].side = 1'b1; vecs[1].n = 4'd4;
    vecs[1].fr[0] = 6'd27; vecs[1].to[0] = 6'd36;
    vecs[1].fr[1] = 6'd4;  vecs[1].to[1] = 6'd36;
    vecs[1].fr[2] = 6'd25; vecs[1].to[2] = 6'd32;
    vecs[1].fr[3] = 6'd0;  vecs[1].to[3] = 6'd32;
    vecs[2].scen = 2'd2; vecs[2].side = 1'b0; vecs[2].n = 4'd5;
    vecs[2].fr[0] = 6'd27; vecs[2].to[0] = 6'd36;
    vecs[2].fr[1] = 6'd4;  vecs[2].to[1] = 6'd36;
    vecs[2].fr[2] = 6'd19; vecs[2].to[2] = 6'd36;
    vecs[2].fr[3] = 6'd25; vecs[2].to[3] = 6'd32;
    vecs[2].fr[4] = 6'd0;  vecs[2].to[4] = 6'd32;
    vecs[3] = vecs[2];
    vecs[3].use3 = 1'b1; vecs[3].n = 4'd3;

    rst = 1'b1; start = 1'b0; abort = 1'b0; side = 1'b0; mv_ready = 1'b0; sel = 1'b0;
    load_scen(0);
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_idle("reset", 8'd0);
    chk("reset_done", done0, 0);
    chk("reset3_busy", busy3, 0);

    // Settle timing: each find holds its board request for Lat+1 cycles
    mv_ready = 1'b1;
    go(1'b0);
    chk("clr_mask", mk0, 32'(MK_CLEAR_ALL));
    chk("clr_busy", busy0, 1);
    step();
    n = 0;
    while (sm0 == 3'(SM_FIND_VICTIM) && n < 20) begin n++; step(); end
    chk("fv_len", n, Lat + 1);
    n = 0;
    while (sm0 == 3'(SM_FIND_AGGR) && n < 20) begin n++; step(); end
    chk("fa_len", n, Lat + 1);
    chk("q_emit_valid", mvv0, 1);
    chk("q_emit_from", from0, 3);
    chk("q_emit_to", to0, 59);
    wait_done(ok);
    chk("q_done", ok, 1);
    step();
    chk("q_count", cnt0, 1);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);
    sel = 1'b0;

    // Backpressure: move held stable, stray start ignored
    load_scen(0);
    mv_ready = 1'b0;
    go(1'b0);
    wait_valid(ok);
    chk("bp_valid_seen", ok, 1);
    f0 = from0;
    t0 = to0;
    chk("bp_from", f0, 3);
    chk("bp_to", t0, 59);
    for (int i = 0; i < 10; i++) begin
      side = 1'b1;
      start = (i == 5);
      step();
      start = 1'b0;
      chk($sformatf("bp_hold%0d_valid", i), mvv0, 1);
      chk($sformatf("bp_hold%0d_from", i), from0, 3);
      chk($sformatf("bp_hold%0d_to", i), to0, 59);
      chk($sformatf("bp_hold%0d_cnt", i), cnt0, 0);
    end
    chk("bp_wtm", wtm0, 0);
    mv_ready = 1'b1;
    step();
    chk("bp_cnt_after", cnt0, 1);
    chk("bp_valid_after", mvv0, 0);
    wait_done(ok);
    chk("bp_done", ok, 1);
    step();

    // Abort in FA
    load_scen(1);
    mv_ready = 1'b0;
    go(1'b1);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (sm0 == 3'(SM_FIND_AGGR)) ok = 1'b1;
      else step();
    end
    chk("ab_fa_seen", ok, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("ab_fa", 8'd0);

    // Abort in EMIT beats a simultaneous handshake; start+abort stays idle
    go(1'b1);
    wait_valid(ok);
    chk("ab_em_seen", ok, 1);
    abort = 1'b1;
    mv_ready = 1'b1;
    step();
    mv_ready = 1'b0;
    chk_idle("ab_em", 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("ab_start_busy", busy0, 0);
    step();

`ifdef MOVEGEN_LEGAL_CHECK_EN
    // Pinned pawn: make flags illegal, unmake still issued, rook emitted
    begin
      int moves;
      int um;
      logic prev_um;
      load_scen(3);
      mv_ready = 1'b1;
      moves = 0;
      um = 0;
      prev_um = 1'b0;
      go(1'b0);
      ok = 1'b0;
      for (int c = 0; c < 500 && !ok; c++) begin
        if (sm0 == 3'(SM_UNMAKE) && !prev_um) um++;
        prev_um = (sm0 == 3'(SM_UNMAKE));
        if (mvv0) begin
          if (moves == 0) begin
            chk("lg_from", from0, 4);
            chk("lg_to", to0, 36);
          end
          moves++;
        end
        if (done0) ok = 1'b1;
        else step();
      end
      chk("lg_done", ok, 1);
      chk("lg_moves", moves, 1);
      chk("lg_unmakes", um, 2);
      step();
      chk("lg_count", cnt0, 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/movegen_seq.md
Name: movegen_seq

Overview:
- Sequencer directly upstream of the board array: drives state_mode/mask_mode/ss1/ss2/wtm, samples the board's registered data_out and illegal outputs.
- Runs the MVV-LVA loop: find the most valuable victim, then enumerate its aggressors cheapest-first, masking each one once it is used.
- Streams (from,to) moves to the search core over a valid/ready handshake.

Parameters:
- BOARD_LAT, 2, cycles from a board-control change to a valid data_out/illegal (range 1..7).
- MAX_MOVES, 218, move cap per generation; on reaching it the block goes straight to DONE.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  pulse; begins generation (ignored unless IDLE)
- abort  in  1  return to IDLE next cycle from any state
- side  in  1  side to move, latched at start
- state_mode  out  3  board operation (pkg enum)
- mask_mode  out  2  board mask operation (pkg enum)
- wtm  out  1  latched side
- ss1 / ss1_valid  out  6 / 1  victim square select
- ss2 / ss2_valid  out  6 / 1  aggressor square select
- board_data  in  7  [6]=found, [5:0]=square
- board_illegal  in  1  king-in-check flag
- mv_valid / mv_ready  out / in  1 / 1  move handshake
- mv_from / mv_to  out  6 / 6  aggressor / victim squares
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at generation end
- move_count  out  8  moves emitted, held until next start

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE. All outputs 0; state_mode=SM_IDLE; mask_mode=MK_NONE.
- Settle counter: every state tagged WAIT loads BOARD_LAT on entry and samples board_data only when the count reaches 0. Board control outputs are held constant during the wait.
- IDLE: on start, latch side to wtm and clear move_count → CLR.
- CLR: mask_mode=MK_CLEAR_ALL for 1 cycle → FV.
- FV (WAIT): state_mode=SM_FIND_VICTIM.
  - Sample found=0 → FIN.
  - Otherwise latch victim → FA.
- FA (WAIT): state_mode=SM_FIND_AGGR, ss1=victim, ss1_valid=1.
  - Sample found=0 → MV.
  - Otherwise latch aggressor → EMIT.
- EMIT: mv_valid=1 with from/to held stable until mv_ready.
  - On handshake: move_count+1 → MA.
  - If move_count+1==MAX_MOVES → FIN.
- MA: mask_mode=MK_AGGR, ss2=aggressor, ss2_valid=1 for 1 cycle → FA.
- MV: mask_mode=MK_VICTIM, ss1=victim, for 1 cycle; also clears aggressor masks → FV.
- FIN: done=1 for 1 cycle → IDLE. move_count is held.
- mv_valid never drops without a handshake, except on abort or rst. These win over everything, including a simultaneous mv_ready: the move is not counted.
- start while busy: ignored. start together with abort: abort wins.
- move_count saturates at MAX_MOVES; it never wraps.

Optional Feature:
- Macro: MOVEGEN_LEGAL_CHECK_EN.
- With the macro: between FA and EMIT, insert MK (state_mode=SM_MAKE, ss1=victim, ss2=aggressor, WAIT), then sample board_illegal, then UM (SM_UNMAKE, WAIT).
  - illegal=1: skip EMIT and go to MA; the move is not counted.
  - illegal=0 → EMIT.
- Without the macro: pseudo-legal moves are emitted; board_illegal is unused and no MK/UM states exist.

Decomposition:
- Package movegen_pkg:
  - state_mode enum: SM_IDLE, SM_FIND_VICTIM, SM_FIND_AGGR, SM_MAKE, SM_UNMAKE.
  - mask_mode enum: MK_NONE, MK_AGGR, MK_VICTIM, MK_CLEAR_ALL.
  - FSM state enum.
  - Board data field positions.
- Sub-module settle_timer: loadable down-counter with a zero flag, shared by all WAIT states.

Test Plan:
- Board model with a white queen on d1 and a black rook on d8, side=white, start → one move from=3 to=59; done pulses; move_count=1; with BOARD_LAT=2 each find samples exactly 2 cycles after entry.
- Two victims (queen e5, pawn a5) each attacked by a pawn and a rook → 4 moves in order: pawn×Q, rook×Q, pawn×P, rook×P.
- mv_ready held low for 10 cycles during EMIT → mv_valid, mv_from and mv_to stable throughout; count increments only on the handshake cycle.
- abort asserted in FA and again in EMIT (with mv_ready=1) → next cycle IDLE, all outputs at reset values, move_count not incremented.
- MAX_MOVES=3 with 5 available moves → exactly 3 moves, done, move_count=3.
- MOVEGEN_LEGAL_CHECK_EN with a pinned attacker whose make raises board_illegal=1 → that move is suppressed, SM_UNMAKE is still issued, the next aggressor is emitted.
